alu: RTL and testbench

Registered 16-bit arithmetic/logic unit for the datapath. Takes two 16-bit operands and a 2-bit operation select, and computes add, subtract, AND or OR. The result and a carry/borrow flag are captured into output registers on the clock edge. It sits between the register-file read ports and the writeback path, and has no handshake: a new operation can be issued every cycle.

---
 rtl/alu.sv | 56 +++++
 tb/tb_alu.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 16-bit ALU: add, subtract, AND, OR with a carry/borrow flag.
// One operation per cycle; the result appears one clock after the operands
// are sampled. Reset is synchronous and active-high.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  sel,
    output logic [15:0] ALU_Result,
    output logic        c
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    op_e         op;
    logic [16:0] a_ext;
    logic [16:0] b_ext;
    logic [16:0] result_next;

    assign op    = op_e'(sel);
    assign a_ext = {1'b0, a};
    assign b_ext = {1'b0, b};

    // Combinational 17-bit result: bit 16 is carry for ADD, borrow for SUB.
    // A 17-bit subtraction of zero-extended operands sets bit 16 exactly
    // when a < b, so it is the borrow directly rather than an inverted carry.
    always_comb begin
        // NOTE: default assigned first so no path leaves result_next unassigned (no latch).
        result_next = '0;
        unique case (op)
            OP_ADD: result_next = a_ext + b_ext;
            OP_SUB: result_next = a_ext - b_ext;
            OP_AND: result_next = {1'b0, a & b};
            OP_OR:  result_next = {1'b0, a | b};
        endcase
    end

    // Output registers; reset wins over the computed result.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all clocked state.
        if (rst) begin
            ALU_Result <= 16'h0000;
            c          <= 1'b0;
        end else begin
            ALU_Result <= result_next[15:0];
            c          <= result_next[16];
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed steps plus a randomized run, with
// expected results pushed to a scoreboard queue when stimulus is driven and
// popped when the registered output is sampled one edge later.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  sel;
    logic [15:0] ALU_Result;
    logic        c;

    typedef struct {
        logic [15:0] result;
        logic        carry;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    alu dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .sel        (sel),
        .ALU_Result (ALU_Result),
        .c          (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference: plain integer arithmetic on unsigned operands.
    function automatic exp_t model(input logic r, input logic [15:0] x,
                                   input logic [15:0] y, input logic [1:0] s,
                                   input string tag);
        exp_t e;
        int   sum;
        e.tag = tag;
        if (r) begin
            e.result = 16'h0000;
            e.carry  = 1'b0;
        end else begin
            case (s)
                2'b00: begin
                    sum      = int'(x) + int'(y);
                    e.result = sum[15:0];
                    e.carry  = (sum > 65535);
                end
                2'b01: begin
                    e.result = x - y;
                    e.carry  = (x < y);
                end
                2'b10: begin
                    e.result = x & y;
                    e.carry  = 1'b0;
                end
                default: begin
                    e.result = x | y;
                    e.carry  = 1'b0;
                end
            endcase
        end
        return e;
    endfunction

    // Drive one cycle of stimulus, push its expectation, then pop and compare
    // the registered output just after the sampling edge.
    task automatic step(input logic r, input logic [15:0] x, input logic [15:0] y,
                        input logic [1:0] s, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r;
        a   = x;
        b   = y;
        sel = s;
        exp_q.push_back(model(r, x, y, s, tag));
        @(posedge clk);
        #1;
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_fails++;
            $error("FAIL %s: scoreboard empty", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            assert (ALU_Result === e.result) else begin
                n_fails++;
                $error("FAIL %s result: got %h expected %h", e.tag, ALU_Result, e.result);
            end
            n_checks++;
            assert (c === e.carry) else begin
                n_fails++;
                $error("FAIL %s carry: got %b expected %b", e.tag, c, e.carry);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = 16'd3;
        b   = 16'd2;
        sel = 2'b00;

        // Reset held for two cycles, then release loads 3 + 2.
        step(1'b1, 16'd3, 16'd2, 2'b00, "reset0");
        step(1'b1, 16'd3, 16'd2, 2'b00, "reset1");
        step(1'b0, 16'd3, 16'd2, 2'b00, "release_add");

        // Opcode sweep.
        step(1'b0, 16'd3, 16'd2, 2'b01, "sweep_sub");
        step(1'b0, 16'd3, 16'd2, 2'b10, "sweep_and");
        step(1'b0, 16'd3, 16'd2, 2'b11, "sweep_or");

        // Carry out of ADD.
        step(1'b0, 16'hFFFF, 16'h0001, 2'b00, "add_wrap");
        step(1'b0, 16'h8000, 16'h8000, 2'b00, "add_msb");

        // Borrow on SUB and the equal-operand case.
        step(1'b0, 16'd2, 16'd3, 2'b01, "sub_borrow");
        step(1'b0, 16'd0, 16'd1, 2'b01, "sub_underflow");
        step(1'b0, 16'h1234, 16'h1234, 2'b01, "sub_equal");

        // Logic ops.
        step(1'b0, 16'hF0F0, 16'h0FF0, 2'b10, "logic_and");
        step(1'b0, 16'hF0F0, 16'h0FF0, 2'b11, "logic_or");

        // Reset asserted alongside a carry-producing ADD discards it.
        step(1'b1, 16'hFFFF, 16'h0001, 2'b00, "reset_midstream");

        // Back-to-back randomized operations.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
